// File: rtl/cache_controller_pkg.sv
// cache_controller_pkg
//   Shared definitions for the 2-way set-associative data cache:
//   field widths, FSM state encoding, the decoded-address struct and
//   small helpers for picking or replacing one word of a cache line.
package cache_controller_pkg;

  localparam int TAG_W   = 10;
  localparam int INDEX_W = 6;
  localparam int LINE_W  = 64;
  localparam int WORD_W  = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic               word_sel;
  } addr_fields_t;

  // Word 0 is the low half of the line (lower byte address).
  function automatic logic [WORD_W-1:0] select_word(input logic [LINE_W-1:0] line,
                                                    input logic              sel);
    return sel ? line[LINE_W-1:WORD_W] : line[WORD_W-1:0];
  endfunction

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic              sel,
                                                   input logic [WORD_W-1:0] word);
    return sel ? {word, line[WORD_W-1:0]} : {line[LINE_W-1:WORD_W], word};
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// cache_way_array
//   Storage for one way of the cache: a valid bit, tag and 64-bit line
//   per set. Combinational read port; synchronous full-line write port
//   that also marks the entry valid.
// Ports:
//   clk, rst      - clock and asynchronous active-low reset (valid bits only)
//   rd_index      - set to read
//   rd_valid/tag/line - contents of that set
//   wr_en         - write strobe
//   wr_index/tag/line - set, tag and line to write
module cache_way_array
  import cache_controller_pkg::*;
#(
  parameter int SETS = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_line,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_line
);

  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] data_mem [SETS];

  // Only the valid bits are reset; tag and data are meaningless while invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_line  = data_mem[rd_index];

endmodule

// File: rtl/cache_controller.sv
// cache_controller
//   2-way set-associative, write-through / no-write-allocate data cache
//   between the MEM pipeline stage and an SRAM controller. Lines are two
//   32-bit words; replacement uses one LRU bit per set.
// Ports:
//   clk, rst            - clock and asynchronous active-low reset
//   address, wdata      - byte address and store data from the MEM stage
//   MEM_R_EN, MEM_W_EN  - load / store request (both set = store)
//   rdata, ready        - load data and request-complete (pause = ~ready)
//   sram_address/wdata  - address and store data to the SRAM controller
//   sram_r_en, sram_w_en- line-fill read / write-through requests
//   sram_rdata          - 64-bit line returned on a fill
//   sram_ready          - one-cycle completion pulse from the SRAM controller
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'd1024,
  parameter int          SETS      = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [31:0]        sram_address,
  output logic [31:0]        sram_wdata,
  output logic               sram_r_en,
  output logic               sram_w_en,
  input  logic [LINE_W-1:0]  sram_rdata,
  input  logic               sram_ready
);

  logic [1:0]        state, next_state;
  logic [SETS-1:0]   lru;
  logic [31:0]       off;
  addr_fields_t      fields;
  logic              unused_off_bits;

  logic              valid0, valid1;
  logic [TAG_W-1:0]  tag0, tag1;
  logic [LINE_W-1:0] line0, line1;
  logic              hit0, hit1, hit, victim;
  logic [LINE_W-1:0] hit_line;

  logic              wr_en0, wr_en1;
  logic [LINE_W-1:0] wr_line;
  logic              lru_we, lru_val;

  assign off             = address - ADDR_BASE;
  assign fields.tag      = off[18:9];
  assign fields.index    = off[8:3];
  assign fields.word_sel = off[2];
  assign unused_off_bits = ^{off[31:19], off[1:0]};

  cache_way_array #(.SETS(SETS)) u_way0 (
    .clk      (clk),
    .rst      (rst),
    .rd_index (fields.index),
    .rd_valid (valid0),
    .rd_tag   (tag0),
    .rd_line  (line0),
    .wr_en    (wr_en0),
    .wr_index (fields.index),
    .wr_tag   (fields.tag),
    .wr_line  (wr_line)
  );

  cache_way_array #(.SETS(SETS)) u_way1 (
    .clk      (clk),
    .rst      (rst),
    .rd_index (fields.index),
    .rd_valid (valid1),
    .rd_tag   (tag1),
    .rd_line  (line1),
    .wr_en    (wr_en1),
    .wr_index (fields.index),
    .wr_tag   (fields.tag),
    .wr_line  (wr_line)
  );

  assign hit0     = valid0 && (tag0 == fields.tag);
  assign hit1     = valid1 && (tag1 == fields.tag);
  assign hit      = hit0 || hit1;
  assign hit_line = hit1 ? line1 : line0;
  // lru = 0 means way0 is the next victim.
  assign victim   = lru[fields.index];

  // Request decode, SRAM handshake and array/LRU write enables. After any
  // access to way w the LRU bit is set so the other way becomes the victim,
  // hence lru_val = 1 exactly when way0 was touched. Reset forces the idle
  // outputs and blocks every write so a pending fill or store is dropped.
  always_comb begin
    next_state   = state;
    ready        = 1'b1;
    rdata        = '0;
    sram_r_en    = 1'b0;
    sram_w_en    = 1'b0;
    sram_address = '0;
    sram_wdata   = '0;
    wr_en0       = 1'b0;
    wr_en1       = 1'b0;
    wr_line      = sram_rdata;
    lru_we       = 1'b0;
    lru_val      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (MEM_W_EN) begin
          ready      = 1'b0;
          next_state = ST_WRITE;
        end else if (MEM_R_EN) begin
          if (hit) begin
            rdata   = select_word(hit_line, fields.word_sel);
            lru_we  = 1'b1;
            lru_val = hit0;
          end else begin
            ready      = 1'b0;
            next_state = ST_FILL;
          end
        end
      end

      ST_FILL: begin
        sram_r_en    = 1'b1;
        sram_address = {address[31:3], 3'b000};
        ready        = 1'b0;
        if (sram_ready) begin
          wr_line    = sram_rdata;
          wr_en0     = ~victim;
          wr_en1     = victim;
          lru_we     = 1'b1;
          lru_val    = ~victim;
          rdata      = select_word(sram_rdata, fields.word_sel);
          ready      = 1'b1;
          next_state = ST_IDLE;
        end
      end

      ST_WRITE: begin
        sram_w_en    = 1'b1;
        sram_address = address;
        sram_wdata   = wdata;
        ready        = 1'b0;
        if (sram_ready) begin
          if (hit) begin
            wr_line = merge_word(hit_line, fields.word_sel, wdata);
            wr_en0  = hit0;
            wr_en1  = hit1;
            lru_we  = 1'b1;
            lru_val = hit0;
          end
          ready      = 1'b1;
          next_state = ST_IDLE;
        end
      end

      default: begin
        next_state = ST_IDLE;
      end
    endcase

    if (!rst) begin
      next_state = ST_IDLE;
      ready      = 1'b1;
      rdata      = '0;
      sram_r_en  = 1'b0;
      sram_w_en  = 1'b0;
      wr_en0     = 1'b0;
      wr_en1     = 1'b0;
      lru_we     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lru <= '0;
    end else if (lru_we) begin
      lru[fields.index] <= lru_val;
    end
  end

endmodule
